// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: emits round keys 0..NUM_ROUNDS one per
// rk_valid/rk_ready handshake, deriving each key on the fly from the previous one.
module key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  state_t       state, state_next;
  logic [127:0] key_next;
  logic [3:0]   idx_next;
  logic         valid_next, busy_next, done_next;
  logic [7:0]   rcon, rcon_next, rcon_xt;
  logic [31:0]  w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
  logic         hs, last;

  assign w0   = round_key[127:96];
  assign w1   = round_key[95:64];
  assign w2   = round_key[63:32];
  assign w3   = round_key[31:0];
  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign rcon_xt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign hs      = rk_valid & rk_ready;
  assign last    = (round_idx == LAST_IDX);

  always_comb begin
    state_next = state;
    key_next   = round_key;
    idx_next   = round_idx;
    valid_next = rk_valid;
    busy_next  = busy;
    done_next  = 1'b0;
    rcon_next  = rcon;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          key_next   = key_in;
          idx_next   = '0;
          rcon_next  = 8'h01;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        // Final key leaves round_key/round_idx untouched so the consumer can still read them.
        if (hs) begin
          if (last) begin
            state_next = IDLE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            key_next  = {n0, n1, n2, n3};
            idx_next  = round_idx + 4'd1;
            rcon_next = rcon_xt;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      state     <= state_next;
      round_key <= key_next;
      round_idx <= idx_next;
      rk_valid  <= valid_next;
      busy      <= busy_next;
      done      <= done_next;
      rcon      <= rcon_next;
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 key expansion vectors.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] A1_KEYS [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam int STALLS [11] = '{3, 0, 7, 1, 5, 2, 0, 6, 4, 1, 2};

  key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; key_in = A1_KEYS[0]; rk_ready = 1'b1;
    repeat (2) step();
    checks++;
    if ({rk_valid, busy, done} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {rk_valid, busy, done});
    end
    checks++;
    if ({round_key, round_idx} !== 132'h0) begin
      failures++; $display("FAIL reset_data: got key=%h idx=%0d expected 0/0", round_key, round_idx);
    end
    rst_n = 1'b1; start = 1'b0;
    step();
    checks++;
    if ({rk_valid, busy, done} !== 3'b000) begin
      failures++; $display("FAIL idle_hold: got %b expected 000", {rk_valid, busy, done});
    end
  endtask

  task automatic test_a1_stream();
    rk_ready = 1'b1;
    do_start(A1_KEYS[0]);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if ({rk_valid, busy, done, round_idx} !== {3'b110, 4'(i)}) begin
        failures++; $display("FAIL a1_status[%0d]: got v/b/d=%b idx=%0d expected 110 idx=%0d", i, {rk_valid, busy, done}, round_idx, i);
      end
      checks++;
      if (round_key !== A1_KEYS[i]) begin
        failures++; $display("FAIL a1_key[%0d]: got %h expected %h", i, round_key, A1_KEYS[i]);
      end
      step();
    end
    checks++;
    if ({rk_valid, busy, done, round_idx} !== {3'b001, 4'd10}) begin
      failures++; $display("FAIL a1_done: got v/b/d=%b idx=%0d expected 001 idx=10", {rk_valid, busy, done}, round_idx);
    end
    checks++;
    if (round_key !== A1_KEYS[10]) begin
      failures++; $display("FAIL a1_key_hold: got %h expected %h", round_key, A1_KEYS[10]);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL a1_done_clear: got %b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    int done_seen = 0;
    rk_ready = 1'b0;
    do_start(A1_KEYS[0]);
    for (int i = 0; i <= 10; i++) begin
      rk_ready = 1'b0;
      for (int s = 0; s < STALLS[i]; s++) begin
        checks++;
        if ({rk_valid, round_idx, round_key} !== {1'b1, 4'(i), A1_KEYS[i]}) begin
          failures++; $display("FAIL bp_stall[%0d.%0d]: got v=%b idx=%0d key=%h expected v=1 idx=%0d key=%h", i, s, rk_valid, round_idx, round_key, i, A1_KEYS[i]);
        end
        step();
      end
      rk_ready = 1'b1;
      checks++;
      if ({rk_valid, round_idx, round_key} !== {1'b1, 4'(i), A1_KEYS[i]}) begin
        failures++; $display("FAIL bp_key[%0d]: got v=%b idx=%0d key=%h expected v=1 idx=%0d key=%h", i, rk_valid, round_idx, round_key, i, A1_KEYS[i]);
      end
      step();
    end
    rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 1) begin
      failures++; $display("FAIL bp_done_count: got %0d expected 1", done_seen);
    end
    checks++;
    if ({rk_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL bp_idle: got v/b=%b expected 00", {rk_valid, busy});
    end
  endtask

  task automatic test_zero_key();
    rk_ready = 1'b1;
    do_start(128'h0);
    step();
    checks++;
    if ({round_idx, round_key} !== {4'd1, 128'h62636363626363636263636362636363}) begin
      failures++; $display("FAIL zero_rk1: got idx=%0d key=%h expected idx=1 key=62636363626363636263636362636363", round_idx, round_key);
    end
    repeat (9) step();
    checks++;
    if ({round_idx, round_key} !== {4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e}) begin
      failures++; $display("FAIL zero_rk10: got idx=%0d key=%h expected idx=10 key=b4ef5bcb3e92e21123e951cf6f8f188e", round_idx, round_key);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL zero_done: got %b expected 1", done);
    end
    step();
  endtask

  task automatic test_start_in_run();
    int done_seen = 0;
    rk_ready = 1'b1;
    do_start(A1_KEYS[0]);
    repeat (4) step();
    key_in = 128'h0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 5; i <= 10; i++) begin
      checks++;
      if ({rk_valid, round_idx, round_key} !== {1'b1, 4'(i), A1_KEYS[i]}) begin
        failures++; $display("FAIL restart_key[%0d]: got v=%b idx=%0d key=%h expected v=1 idx=%0d key=%h", i, rk_valid, round_idx, round_key, i, A1_KEYS[i]);
      end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 1) begin
      failures++; $display("FAIL restart_done_count: got %0d expected 1", done_seen);
    end
  endtask

  task automatic test_mid_reset();
    int done_seen = 0;
    rk_ready = 1'b1;
    do_start(A1_KEYS[0]);
    repeat (6) step();
    checks++;
    if (round_idx !== 4'd6) begin
      failures++; $display("FAIL mrst_pre_idx: got %0d expected 6", round_idx);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({rk_valid, busy, done, round_key} !== {3'b000, 128'h0}) begin
      failures++; $display("FAIL mrst_state: got v/b/d=%b key=%h expected 000 key=0", {rk_valid, busy, done}, round_key);
    end
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 0) begin
      failures++; $display("FAIL mrst_no_done: got %0d expected 0", done_seen);
    end
    do_start(A1_KEYS[0]);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if ({rk_valid, round_idx, round_key} !== {1'b1, 4'(i), A1_KEYS[i]}) begin
        failures++; $display("FAIL mrst_key[%0d]: got v=%b idx=%0d key=%h expected v=1 idx=%0d key=%h", i, rk_valid, round_idx, round_key, i, A1_KEYS[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL mrst_done: got %b expected 1", done);
    end
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    do_start(A1_KEYS[0]);
    repeat (11) step();
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL b2b_done: got %b expected 1", done);
    end
    do_start(128'h000102030405060708090a0b0c0d0e0f);
    checks++;
    if ({rk_valid, busy, round_idx, round_key} !== {2'b11, 4'd0, 128'h000102030405060708090a0b0c0d0e0f}) begin
      failures++; $display("FAIL b2b_rk0: got v/b=%b idx=%0d key=%h expected 11 idx=0 key=000102030405060708090a0b0c0d0e0f", {rk_valid, busy}, round_idx, round_key);
    end
    repeat (10) step();
    checks++;
    if ({round_idx, round_key} !== {4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5}) begin
      failures++; $display("FAIL b2b_rk10: got idx=%0d key=%h expected idx=10 key=13111d7fe3944a17f307a78b4d2b30c5", round_idx, round_key);
    end
    step();
    checks++;
    if ({rk_valid, busy, done} !== 3'b001) begin
      failures++; $display("FAIL b2b_end: got v/b/d=%b expected 001", {rk_valid, busy, done});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    test_reset();
    test_a1_stream();
    test_backpressure();
    test_zero_key();
    test_start_in_run();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Iterative AES-128 key expansion engine; the direct upstream stage of the round-key XOR stage.
- Takes a 128-bit cipher key on a start pulse and emits round keys 0..10 in order.
- Emits one round key per valid/ready handshake, so the round controller can consume each key in step with the datapath.
- One round key is computed per accepted handshake: 4 S-box lookups, RotWord, Rcon and an XOR chain. No 176-byte key store.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted; fixed at 10 for AES-128, and other values are not supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin expansion of key_in; sampled only in IDLE
- key_in  input  128  cipher key; bits [127:120] = byte 0, w0 = [127:96]
- rk_ready  input  1  consumer accepts round_key this cycle
- round_key  output  128  current round key, same byte order as key_in
- round_idx  output  4  index 0..10 of round_key
- rk_valid  output  1  round_key/round_idx valid
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - round_key=0, round_idx=0, rk_valid=0, busy=0, done=0.
  - The internal Rcon register is set to 8'h01.
  - Reset wins over every other input. Reset asserted mid-RUN aborts the expansion, and no done pulse is produced.
- States: IDLE and RUN.
- IDLE, start=1 at edge t:
  - Latch key_in into round_key; round_idx=0; rcon=8'h01.
  - Go to RUN; rk_valid=1 and busy=1 from t+1.
  - Latency is 1 cycle from start to round key 0.
- IDLE, start=0: hold all outputs. done returns to 0 one cycle after it pulses.
- RUN, rk_valid=1 and rk_ready=0: hold round_key, round_idx and rk_valid unchanged (stall of any length).
- RUN, handshake (rk_valid & rk_ready) with round_idx < NUM_ROUNDS, next key registered at the same edge:
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - round_idx increments by 1.
  - rcon = xtime(rcon): shift left 1, XOR 8'h1B if bit 7 was set. Sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - rk_valid stays 1, so back-to-back keys come 1 per cycle while rk_ready=1.
- RUN, handshake with round_idx == NUM_ROUNDS:
  - Go to IDLE; rk_valid=0 and busy=0 next cycle.
  - done=1 for exactly one cycle.
  - round_key and round_idx keep their last values.
- start while in RUN: ignored; no restart and no corruption.
- start in the same cycle that done is high: accepted, because the state is IDLE.
- S-box: combinational byte substitution per FIPS-197, 4 instances.
- Entire block is synchronous; no output is combinationally dependent on an input.

Test Plan:
- FIPS-197 A.1 vector, rk_ready tied 1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse at cycle t.
  - Round key 0 = key_in at t+1.
  - Round key 1 = a0fafe1788542cb123a339392a6c7605.
  - Round key 2 = f2c295f27a96b9435935807a7359f67f.
  - Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+11.
  - done=1 only at t+12; busy falls at t+12.
- Backpressure: same key, rk_ready toggled randomly with stalls of 0–7 cycles.
  - Identical key sequence to the previous scenario, each key presented exactly once, round_idx strictly 0..10.
  - round_key is stable while rk_valid=1 and rk_ready=0.
- All-zero key, rk_ready=1:
  - Round key 1 = 62636363626363636263636362636363.
  - Round key 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start re-asserted at round_idx=4: ignored; the remaining keys match the original expansion and done pulses once.
- rst_n=0 for 1 cycle at round_idx=6:
  - Next cycle rk_valid=0, busy=0, done=0, round_key=0.
  - A new start with the A.1 key reproduces the full A.1 sequence from round 0.
- start asserted in the done cycle with key 000102030405060708090a0b0c0d0e0f: a new expansion begins; round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
